reorder_buffer: RTL and testbench
=================================

REORDER_BUFFER -- requirements
Module: reorder_buffer

Interface
REQ-001 clk1  input  1  sole clock; all state updates on its rising edge.
REQ-002 rst  input  1  reset, synchronous, active-high.
REQ-003 alloc_valid  input  1  issue stage requests a new entry this cycle.
REQ-004 alloc_func  input  4  opcode of the issuing instruction: 0000 add, 0001 sub, 0010 mul, 0011 div, 0100 load, 0101 store, 0110/0111 branch.
REQ-005 alloc_rd  input  4  destination register of the issuing instruction.
REQ-006 alloc_ready  output  1  an entry is free; equals (count < 8), combinational from registered count.
REQ-007 alloc_idx  output  3  current tail pointer, i.e. the ROB index the next accepted allocation receives and the index the reservation station records.
REQ-008 cdb_valid  input  1  execution unit presents a result.
REQ-009 cdb_idx  input  3  ROB index of that result.
REQ-010 cdb_data  input  16  result value.
REQ-011 flush  input  1  discard all in-flight entries.
REQ-012 commit_valid  output  1  registered; one entry retired this cycle.
REQ-013 commit_idx  output  3  registered; ROB index of the retired entry.
REQ-014 commit_func  output  4  registered; opcode of the retired entry.
REQ-015 wb_we  output  1  registered; register-bank write enable for the retired entry.
REQ-016 wb_rd  output  4  registered; register-bank write address.
REQ-017 wb_data  output  16  registered; register-bank write data.
REQ-018 count  output  4  registered; number of valid entries, 0..8.

Function
REQ-019 Storage: 8 entries, each holding valid, ready, func[3:0], rd[3:0] and data[15:0]; head and tail pointers are 3 bits and wrap 7->0.
REQ-020 Allocate: on alloc_valid && alloc_ready, write entry[tail] = {valid 1, ready 0, alloc_func, alloc_rd, data 0} and set tail = tail+1.
REQ-021 Allocation when alloc_ready=0 is ignored, with no state change, even if a commit occurs in the same cycle.
REQ-022 CDB capture: on cdb_valid, if entry[cdb_idx] is valid and not ready, set ready=1 and data=cdb_data.
REQ-023 A CDB result for an invalid or already-ready entry is ignored.
REQ-024 Commit: each cycle, if entry[head] is valid and ready, clear its valid bit, set head = head+1, and register commit_valid=1, commit_idx=head, commit_func, wb_rd, wb_data.
REQ-025 wb_we=1 only when the committed func is in {0000,0001,0010,0011,0100}; store and branch commits retire with wb_we=0.
REQ-026 At most one commit per cycle, strictly in allocation order; a ready entry behind a non-ready head waits.
REQ-027 A cycle with no commit drives commit_valid=0 and wb_we=0; wb_rd, wb_data, commit_idx and commit_func hold their last values.
REQ-028 Latency: cdb_valid sampled at edge E makes the entry ready after E; if it is at head, commit_valid is high after edge E+1. There is no same-cycle bypass from the CDB to commit.
REQ-029 Count update: count += 1 on an accepted allocation and -= 1 on a commit; a simultaneous allocation and commit leave count unchanged.
REQ-030 Same-edge allocation and CDB capture to the same index: the entry is invalid at sampling, so the CDB result is ignored and the allocation wins.
REQ-031 flush overrides allocation, CDB capture and commit: clear all valid bits, set head=tail=0 and count=0, and drive commit_valid=0 and wb_we=0 on the next cycle.

Reset
REQ-032 When rst is sampled high: all entries invalid, head=tail=0, count=0, commit_valid=0, wb_we=0, wb_rd=0, wb_data=0, commit_idx=0, commit_func=0; hence alloc_ready=1 and alloc_idx=0.
REQ-033 rst has priority over flush and all other inputs; an asserted rst mid-operation discards all pending entries with no commit output.

Verification
REQ-034 After rst, allocate three entries (func 0000, rd 1, 2, 3) -> alloc_idx reads 0, 1, 2 at the accepting edges, count=3, commit_valid stays 0.
REQ-035 In the same state, CDB idx2=0x0030 then idx0=0x0010 -> commit idx0 (wb_rd 1, wb_data 0x0010) only; then CDB idx1=0x0020 -> idx1 and idx2 commit on consecutive cycles.
REQ-036 Allocate 8 entries -> alloc_ready=0 and a 9th alloc_valid is ignored; complete and commit the head -> count=7 and alloc_ready=1.
REQ-037 Run 10 allocate/complete/commit sequences -> alloc_idx and commit_idx follow 0..7,0,1 with no loss or duplication.
REQ-038 Commit a store (0101) entry and a branch (0110) entry -> commit_valid=1 and wb_we=0 for each; a following load (0100) commits with wb_we=1.
REQ-039 With 4 entries pending, assert flush together with cdb_valid for the head -> next cycle count=0, commit_valid=0, alloc_idx=0.

Source files
------------

// File: rtl/reorder_buffer.sv
// reorder_buffer: eight-entry in-order retirement buffer.
//   Entries are allocated at the tail as instructions issue. They become ready
//   when their result arrives on the CDB. They retire from the head, strictly
//   in allocation order, at most one per cycle.
// Ports:
//   clk1, rst                          clock and synchronous active-high reset
//   alloc_valid/func/rd                issue-side allocation request
//   alloc_ready, alloc_idx             free-slot flag and the index the next allocation receives
//   cdb_valid/idx/data                 result broadcast from the execution units
//   flush                              discard every in-flight entry
//   commit_valid/idx/func              registered retirement report
//   wb_we/wb_rd/wb_data                registered register-bank write port
//   count                              registered occupancy, 0..8
module reorder_buffer (
    input  logic        clk1,
    input  logic        rst,
    input  logic        alloc_valid,
    input  logic [3:0]  alloc_func,
    input  logic [3:0]  alloc_rd,
    output logic        alloc_ready,
    output logic [2:0]  alloc_idx,
    input  logic        cdb_valid,
    input  logic [2:0]  cdb_idx,
    input  logic [15:0] cdb_data,
    input  logic        flush,
    output logic        commit_valid,
    output logic [2:0]  commit_idx,
    output logic [3:0]  commit_func,
    output logic        wb_we,
    output logic [3:0]  wb_rd,
    output logic [15:0] wb_data,
    output logic [3:0]  count
);

    logic [7:0]  valid_r;
    logic [7:0]  ready_r;
    logic [3:0]  func_r [8];
    logic [3:0]  rd_r   [8];
    logic [15:0] data_r [8];
    logic [2:0]  head_r;
    logic [2:0]  tail_r;
    logic [3:0]  count_r;

    logic        commit_valid_r;
    logic [2:0]  commit_idx_r;
    logic [3:0]  commit_func_r;
    logic        wb_we_r;
    logic [3:0]  wb_rd_r;
    logic [15:0] wb_data_r;

    logic        alloc_ready_s;
    logic        alloc_fire_s;
    logic        cdb_fire_s;
    logic        commit_fire_s;
    logic [3:0]  count_next_s;

    // Arithmetic and load results go to the register bank; stores and branches do not.
    function automatic logic func_writes_reg(input logic [3:0] func);
        logic w;
        case (func)
            4'd0, 4'd1, 4'd2, 4'd3, 4'd4: w = 1'b1;
            default:                      w = 1'b0;
        endcase
        return w;
    endfunction

    assign alloc_ready_s = (count_r < 4'd8);
    assign alloc_ready   = alloc_ready_s;
    assign alloc_idx     = tail_r;
    assign count         = count_r;
    assign commit_valid  = commit_valid_r;
    assign commit_idx    = commit_idx_r;
    assign commit_func   = commit_func_r;
    assign wb_we         = wb_we_r;
    assign wb_rd         = wb_rd_r;
    assign wb_data       = wb_data_r;

    // Event decode from registered state. The CDB only sets ready at the edge,
    // so commit never sees a result in the same cycle it arrives.
    always_comb begin
        alloc_fire_s  = alloc_valid & alloc_ready_s;
        cdb_fire_s    = cdb_valid & valid_r[cdb_idx] & ~ready_r[cdb_idx];
        commit_fire_s = valid_r[head_r] & ready_r[head_r];
        count_next_s  = count_r;
        case ({alloc_fire_s, commit_fire_s})
            2'b10:   count_next_s = count_r + 4'd1;
            2'b01:   count_next_s = count_r - 4'd1;
            default: count_next_s = count_r;
        endcase
    end

    // Entry storage, pointers and registered retirement outputs.
    // When the buffer is full no allocation is accepted, so the tail write
    // and the head clear always target different entries.
    always_ff @(posedge clk1) begin
        if (rst) begin
            valid_r        <= 8'h00;
            ready_r        <= 8'h00;
            for (int i = 0; i < 8; i++) begin
                func_r[i] <= 4'h0;
                rd_r[i]   <= 4'h0;
                data_r[i] <= 16'h0000;
            end
            head_r         <= 3'd0;
            tail_r         <= 3'd0;
            count_r        <= 4'd0;
            commit_valid_r <= 1'b0;
            commit_idx_r   <= 3'd0;
            commit_func_r  <= 4'h0;
            wb_we_r        <= 1'b0;
            wb_rd_r        <= 4'h0;
            wb_data_r      <= 16'h0000;
        end else if (flush) begin
            valid_r        <= 8'h00;
            head_r         <= 3'd0;
            tail_r         <= 3'd0;
            count_r        <= 4'd0;
            commit_valid_r <= 1'b0;
            wb_we_r        <= 1'b0;
        end else begin
            if (cdb_fire_s) begin
                ready_r[cdb_idx] <= 1'b1;
                data_r[cdb_idx]  <= cdb_data;
            end
            if (alloc_fire_s) begin
                valid_r[tail_r] <= 1'b1;
                ready_r[tail_r] <= 1'b0;
                func_r[tail_r]  <= alloc_func;
                rd_r[tail_r]    <= alloc_rd;
                data_r[tail_r]  <= 16'h0000;
                tail_r          <= tail_r + 3'd1;
            end
            if (commit_fire_s) begin
                valid_r[head_r] <= 1'b0;
                head_r          <= head_r + 3'd1;
                commit_valid_r  <= 1'b1;
                commit_idx_r    <= head_r;
                commit_func_r   <= func_r[head_r];
                wb_we_r         <= func_writes_reg(func_r[head_r]);
                wb_rd_r         <= rd_r[head_r];
                wb_data_r       <= data_r[head_r];
            end else begin
                commit_valid_r  <= 1'b0;
                wb_we_r         <= 1'b0;
            end
            count_r <= count_next_s;
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// tb_reorder_buffer: directed stimulus with a commit scoreboard.
// The stimulus process pushes each expected retirement, in hand-derived order,
// into sb_q. A separate monitor pops one entry per observed commit and compares it.
module tb_reorder_buffer;

    logic        clk1;
    logic        rst;
    logic        alloc_valid;
    logic [3:0]  alloc_func;
    logic [3:0]  alloc_rd;
    logic        alloc_ready;
    logic [2:0]  alloc_idx;
    logic        cdb_valid;
    logic [2:0]  cdb_idx;
    logic [15:0] cdb_data;
    logic        flush;
    logic        commit_valid;
    logic [2:0]  commit_idx;
    logic [3:0]  commit_func;
    logic        wb_we;
    logic [3:0]  wb_rd;
    logic [15:0] wb_data;
    logic [3:0]  count;

    typedef struct {
        logic [2:0]  idx;
        logic [3:0]  func;
        logic [3:0]  rd;
        logic [15:0] data;
        logic        we;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    logic mon_en   = 1'b0;

    reorder_buffer dut (
        .clk1         (clk1),
        .rst          (rst),
        .alloc_valid  (alloc_valid),
        .alloc_func   (alloc_func),
        .alloc_rd     (alloc_rd),
        .alloc_ready  (alloc_ready),
        .alloc_idx    (alloc_idx),
        .cdb_valid    (cdb_valid),
        .cdb_idx      (cdb_idx),
        .cdb_data     (cdb_data),
        .flush        (flush),
        .commit_valid (commit_valid),
        .commit_idx   (commit_idx),
        .commit_func  (commit_func),
        .wb_we        (wb_we),
        .wb_rd        (wb_rd),
        .wb_data      (wb_data),
        .count        (count)
    );

    initial clk1 = 1'b0;
    always #5 clk1 = ~clk1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk1);
        #1;
    endtask

    task automatic expect_commit(input logic [2:0] idx, input logic [3:0] func,
                                 input logic [3:0] rd, input logic [15:0] data,
                                 input logic we);
        exp_t e;
        e.idx = idx; e.func = func; e.rd = rd; e.data = data; e.we = we;
        sb_q.push_back(e);
    endtask

    task automatic do_alloc(input logic [3:0] f, input logic [3:0] r, input logic [2:0] exp_idx);
        chk("alloc_ready_before_alloc", 32'(alloc_ready), 32'd1);
        chk("alloc_idx", 32'(alloc_idx), 32'(exp_idx));
        alloc_valid = 1'b1;
        alloc_func  = f;
        alloc_rd    = r;
        tick();
        alloc_valid = 1'b0;
    endtask

    task automatic do_cdb(input logic [2:0] idx, input logic [15:0] data);
        cdb_valid = 1'b1;
        cdb_idx   = idx;
        cdb_data  = data;
        tick();
        cdb_valid = 1'b0;
    endtask

    // Monitor: every observed commit must match the head of the scoreboard;
    // cycles without a commit must not write the register bank.
    always @(negedge clk1) begin
        if (mon_en) begin
            if (commit_valid === 1'b1) begin
                if (sb_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_commit: got idx %0d, expected no commit at %0t",
                             commit_idx, $time);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    chk("commit_idx",  32'(commit_idx),  32'(e.idx));
                    chk("commit_func", 32'(commit_func), 32'(e.func));
                    chk("wb_rd",       32'(wb_rd),       32'(e.rd));
                    chk("wb_data",     32'(wb_data),     32'(e.data));
                    chk("wb_we",       32'(wb_we),       32'(e.we));
                end
            end else begin
                chk("idle_wb_we", 32'(wb_we), 32'd0);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; alloc_valid = 1'b0; alloc_func = 4'h0; alloc_rd = 4'h0;
        cdb_valid = 1'b0; cdb_idx = 3'd0; cdb_data = 16'h0000; flush = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        // Reset state
        chk("rst_count",        32'(count),        32'd0);
        chk("rst_alloc_ready",  32'(alloc_ready),  32'd1);
        chk("rst_alloc_idx",    32'(alloc_idx),    32'd0);
        chk("rst_commit_valid", 32'(commit_valid), 32'd0);
        chk("rst_wb_we",        32'(wb_we),        32'd0);
        chk("rst_wb_rd",        32'(wb_rd),        32'd0);
        chk("rst_wb_data",      32'(wb_data),      32'd0);
        chk("rst_commit_idx",   32'(commit_idx),   32'd0);
        chk("rst_commit_func",  32'(commit_func),  32'd0);
        mon_en = 1'b1;

        // Three allocations, nothing commits
        do_alloc(4'h0, 4'd1, 3'd0);
        do_alloc(4'h0, 4'd2, 3'd1);
        do_alloc(4'h0, 4'd3, 3'd2);
        chk("three_alloc_count", 32'(count), 32'd3);

        // Out-of-order completion: only idx0 may retire until idx1 completes
        expect_commit(3'd0, 4'h0, 4'd1, 16'h0010, 1'b1);
        do_cdb(3'd2, 16'h0030);
        do_cdb(3'd0, 16'h0010);
        tick();
        chk("head_commit_valid", 32'(commit_valid), 32'd1);
        chk("head_commit_count", 32'(count), 32'd2);
        tick();
        chk("blocked_commit_valid", 32'(commit_valid), 32'd0);
        chk("blocked_count", 32'(count), 32'd2);
        expect_commit(3'd1, 4'h0, 4'd2, 16'h0020, 1'b1);
        expect_commit(3'd2, 4'h0, 4'd3, 16'h0030, 1'b1);
        do_cdb(3'd1, 16'h0020);
        tick();
        chk("consec_commit1_valid", 32'(commit_valid), 32'd1);
        chk("consec_commit1_idx",   32'(commit_idx),   32'd1);
        tick();
        chk("consec_commit2_valid", 32'(commit_valid), 32'd1);
        chk("consec_commit2_idx",   32'(commit_idx),   32'd2);
        chk("drained_count", 32'(count), 32'd0);

        // Fill all 8 entries starting from head=tail=3
        for (int i = 0; i < 8; i++) begin
            logic [2:0] ix;
            ix = 3'(i + 3);
            do_alloc(4'h0, 4'(i), ix);
        end
        chk("full_count",       32'(count),       32'd8);
        chk("full_alloc_ready", 32'(alloc_ready), 32'd0);
        alloc_valid = 1'b1; alloc_func = 4'h2; alloc_rd = 4'd15;
        tick();
        alloc_valid = 1'b0;
        chk("ninth_ignored_count", 32'(count),     32'd8);
        chk("ninth_ignored_idx",   32'(alloc_idx), 32'd3);
        expect_commit(3'd3, 4'h0, 4'd0, 16'hA5A5, 1'b1);
        do_cdb(3'd3, 16'hA5A5);
        // Allocation attempt while full, on the same edge the head commits
        alloc_valid = 1'b1; alloc_func = 4'h5; alloc_rd = 4'd9;
        tick();
        alloc_valid = 1'b0;
        chk("after_full_commit_count", 32'(count),       32'd7);
        chk("after_full_commit_ready", 32'(alloc_ready), 32'd1);
        chk("after_full_commit_idx",   32'(alloc_idx),   32'd3);

        // Reset mid-operation beats a pending CDB and flush
        rst = 1'b1; flush = 1'b1; cdb_valid = 1'b1; cdb_idx = 3'd4; cdb_data = 16'h7777;
        tick();
        rst = 1'b0; flush = 1'b0; cdb_valid = 1'b0;
        chk("midrst_count",        32'(count),        32'd0);
        chk("midrst_alloc_idx",    32'(alloc_idx),    32'd0);
        chk("midrst_commit_valid", 32'(commit_valid), 32'd0);
        tick();
        tick();
        chk("midrst_later_count", 32'(count), 32'd0);

        // Ten allocate/complete/commit rounds across the wrap
        for (int i = 0; i < 10; i++) begin
            logic [2:0]  ix;
            logic [3:0]  f;
            logic [15:0] d;
            ix = 3'(i % 8);
            f  = 4'(i % 5);
            d  = 16'h0100 + 16'(i);
            do_alloc(f, 4'(i + 1), ix);
            expect_commit(ix, f, 4'(i + 1), d, 1'b1);
            do_cdb(ix, d);
            tick();
            chk("seq_commit_valid", 32'(commit_valid), 32'd1);
            chk("seq_commit_idx",   32'(commit_idx),   32'(ix));
        end
        chk("seq_count", 32'(count), 32'd0);

        // Store and branch retire without a register write; load writes
        do_alloc(4'h5, 4'd7, 3'd2);
        do_alloc(4'h6, 4'd8, 3'd3);
        do_alloc(4'h4, 4'd9, 3'd4);
        expect_commit(3'd2, 4'h5, 4'd7, 16'h0051, 1'b0);
        expect_commit(3'd3, 4'h6, 4'd8, 16'h0062, 1'b0);
        expect_commit(3'd4, 4'h4, 4'd9, 16'h0094, 1'b1);
        do_cdb(3'd4, 16'h0094);
        do_cdb(3'd3, 16'h0062);
        do_cdb(3'd2, 16'h0051);
        tick(); tick(); tick(); tick();
        chk("mixed_count",       32'(count),       32'd0);
        chk("hold_wb_rd",        32'(wb_rd),       32'd9);
        chk("hold_wb_data",      32'(wb_data),     32'h0094);
        chk("hold_commit_idx",   32'(commit_idx),  32'd4);
        chk("hold_commit_func",  32'(commit_func), 32'd4);

        // Flush with four pending, alongside a CDB result for the head
        do_alloc(4'h0, 4'd1, 3'd5);
        do_alloc(4'h1, 4'd2, 3'd6);
        do_alloc(4'h2, 4'd3, 3'd7);
        do_alloc(4'h3, 4'd4, 3'd0);
        chk("preflush_count", 32'(count), 32'd4);
        flush = 1'b1; cdb_valid = 1'b1; cdb_idx = 3'd5; cdb_data = 16'h5A5A;
        tick();
        flush = 1'b0; cdb_valid = 1'b0;
        chk("flush_count",        32'(count),        32'd0);
        chk("flush_commit_valid", 32'(commit_valid), 32'd0);
        chk("flush_alloc_idx",    32'(alloc_idx),    32'd0);
        chk("flush_alloc_ready",  32'(alloc_ready),  32'd1);
        tick();
        tick();
        chk("postflush_count", 32'(count), 32'd0);
        do_alloc(4'h0, 4'd4, 3'd0);
        expect_commit(3'd0, 4'h0, 4'd4, 16'hBEEF, 1'b1);
        do_cdb(3'd0, 16'hBEEF);
        tick();
        chk("postflush_commit_valid", 32'(commit_valid), 32'd1);

        // CDB for an invalid entry is ignored; a second CDB for a ready entry is ignored
        do_cdb(3'd3, 16'h1234);
        tick();
        chk("invalid_cdb_count", 32'(count), 32'd0);
        do_alloc(4'h1, 4'd5, 3'd1);
        expect_commit(3'd1, 4'h1, 4'd5, 16'h1111, 1'b1);
        do_cdb(3'd1, 16'h1111);
        do_cdb(3'd1, 16'h2222);
        chk("first_cdb_wins_valid", 32'(commit_valid), 32'd1);

        // Same-edge allocation and CDB to the tail: the CDB result is dropped
        alloc_valid = 1'b1; alloc_func = 4'h2; alloc_rd = 4'd6;
        cdb_valid = 1'b1; cdb_idx = 3'd2; cdb_data = 16'h5555;
        tick();
        alloc_valid = 1'b0; cdb_valid = 1'b0;
        chk("same_edge_count", 32'(count),     32'd1);
        chk("same_edge_tail",  32'(alloc_idx), 32'd3);
        tick(); tick(); tick();
        chk("same_edge_not_ready_count", 32'(count), 32'd1);
        expect_commit(3'd2, 4'h2, 4'd6, 16'h6666, 1'b1);
        do_cdb(3'd2, 16'h6666);
        tick();
        chk("late_cdb_commit_valid", 32'(commit_valid), 32'd1);
        chk("final_count", 32'(count), 32'd0);

        tick(); tick(); tick();
        chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
